ms_uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one MS UART transmit engine among `NREQ` byte requesters.
- Each requester presents a byte with a REQ/ACK handshake. The arbiter grants one requester, drives the engine's START/DIN inputs and tracks the engine's BUSY output through the frame. It then pulses ACK to the winner.
- Sits between on-chip byte sources (status reporter, loopback echo, host command responder) and the TX engine, in the same clock domain as the baud generator.

---
 rtl/ms_uart_tx_arbiter_if.sv | 25 ++
 rtl/ms_uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_ms_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ms_uart_tx_arbiter_if.sv
// Requester/engine bundle for the shared MS UART transmit arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters and engine.
interface ms_uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   REQ;
  logic [8*NREQ-1:0] DATA;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   ACK;
  logic              ERR;
  logic              TX_START;
  logic [7:0]        TX_DIN;
  logic              TX_BUSY;
  logic              ACTIVE;

  modport master (
    input  REQ, DATA, TX_BUSY,
    output GNT, ACK, ERR, TX_START, TX_DIN, ACTIVE
  );

  modport slave (
    output REQ, DATA, TX_BUSY,
    input  GNT, ACK, ERR, TX_START, TX_DIN, ACTIVE
  );
endinterface

// File: rtl/ms_uart_tx_arbiter.sv
// Round-robin arbiter sharing one MS UART TX engine among NREQ byte requesters.
// The grant is held through START/WAIT/DONE, and the winner gets a one-cycle ACK (with ERR on timeout).
module ms_uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 255
) (
  input logic                  CLK,
  input logic                  RESETN,
  ms_uart_tx_arbiter_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_ptr, w_ptr_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_err_flag, w_err_flag_next;
  logic [NREQ-1:0] r_gnt, w_gnt_next;
  logic            r_tx_start, w_tx_start_next;
  logic [7:0]      r_tx_din, w_tx_din_next;
  logic            w_any;
  logic [PW-1:0]   w_win;
  logic            w_done;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_any && bus.REQ[wrap_idx(r_ptr, i)]) begin
        w_any = 1'b1;
        w_win = wrap_idx(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_cnt;
    w_err_flag_next = r_err_flag;
    w_gnt_next      = r_gnt;
    w_tx_start_next = r_tx_start;
    w_tx_din_next   = r_tx_din;
    case (r_state)
      S_IDLE: begin
        if (w_any && !bus.TX_BUSY) begin
          w_state_next    = S_START;
          w_ptr_next      = w_win;
          w_gnt_next      = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_tx_din_next   = bus.DATA[8*w_win +: 8];
          w_tx_start_next = 1'b1;
          w_cnt_next      = '0;
        end
      end
      S_START: begin
        // BUSY takes precedence over a timeout in the same cycle.
        if (bus.TX_BUSY) begin
          w_tx_start_next = 1'b0;
          w_state_next    = S_WAIT;
        end else if (r_cnt == CNT_LIM) begin
          w_tx_start_next = 1'b0;
          w_err_flag_next = 1'b1;
          w_state_next    = S_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.TX_BUSY) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next    = S_IDLE;
        w_gnt_next      = '0;
        w_err_flag_next = 1'b0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_state    <= S_IDLE;
      r_ptr      <= PTR_RST;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
      r_gnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_din   <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_cnt      <= w_cnt_next;
      r_err_flag <= w_err_flag_next;
      r_gnt      <= w_gnt_next;
      r_tx_start <= w_tx_start_next;
      r_tx_din   <= w_tx_din_next;
    end
  end

  assign w_done       = (r_state == S_DONE);
  assign bus.GNT      = r_gnt;
  assign bus.ACK      = r_gnt & {NREQ{w_done}};
  assign bus.ERR      = w_done & r_err_flag;
  assign bus.TX_START = r_tx_start;
  assign bus.TX_DIN   = r_tx_din;
  assign bus.ACTIVE   = (r_state != S_IDLE);
endmodule

// File: tb/tb_ms_uart_tx_arbiter.sv
// Directed, table-driven bench for ms_uart_tx_arbiter (NREQ=4, START_TIMEOUT=16) with a simple TX engine model.
module tb_ms_uart_tx_arbiter;
  logic CLK = 1'b0;
  logic RESETN;
  int   n_cmp = 0;
  int   n_mis = 0;

  int   eng_delay = 0;
  int   eng_hold  = 1;
  logic force_busy = 1'b0;
  logic r_eng_busy = 1'b0;
  int   e_cnt = 0;

  ms_uart_tx_arbiter_if #(.NREQ(4)) bus ();

  ms_uart_tx_arbiter #(.NREQ(4), .START_TIMEOUT(16)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus.master)
  );

  always #5 CLK = ~CLK;

  // Engine: raises BUSY so the arbiter samples it eng_delay cycles into TX_START, holds it eng_hold cycles.
  // eng_delay==0 means the engine never answers.
  assign bus.TX_BUSY = r_eng_busy | force_busy;
  always @(posedge CLK) begin
    if (!r_eng_busy && bus.TX_START && eng_delay > 0) begin
      if (e_cnt + 1 == eng_delay - 1) begin
        r_eng_busy <= 1'b1;
        e_cnt      <= 0;
      end else begin
        e_cnt <= e_cnt + 1;
      end
    end else if (r_eng_busy) begin
      if (e_cnt + 1 == eng_hold) begin
        r_eng_busy <= 1'b0;
        e_cnt      <= 0;
      end else begin
        e_cnt <= e_cnt + 1;
      end
    end else begin
      e_cnt <= 0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RESETN  = 1'b1;
    bus.REQ = 4'b0000;
    repeat (3) @(negedge CLK);
    RESETN = 1'b0;
  endtask

  // One full transaction from REQ to the idle cycle after ACK.
  task automatic run_txn(input string nm, input logic [3:0] req, input logic [31:0] data,
                         input int d, input int h, input int exp_w, input logic [7:0] exp_din,
                         input logic exp_err, input int exp_start, input int exp_wait,
                         input bit chk_lat, input bit mutate);
    int lat, ns, nw, ack_pre;
    logic [3:0] exp_g;
    exp_g = 4'b0001;
    exp_g = exp_g << exp_w;
    eng_delay = d;
    eng_hold  = h;
    bus.DATA  = data;
    bus.REQ   = req;
    lat = 0;
    ack_pre = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (bus.ACK != 4'b0000) ack_pre++;
    end while (bus.GNT == 4'b0000 && lat < 300);
    if (chk_lat) chk({nm, "_lat"}, 64'(lat), 64'd1);
    chk({nm, "_ack_pre"}, 64'(ack_pre), 64'd0);
    chk({nm, "_gnt"}, {59'd0, bus.ACTIVE, bus.GNT}, {59'd0, 1'b1, exp_g});
    chk({nm, "_din"}, 64'(bus.TX_DIN), 64'(exp_din));
    if (mutate) begin
      bus.REQ[exp_w]           = 1'b0;
      bus.DATA[8*exp_w +: 8]   = ~exp_din;
    end
    ns = 0;
    while (bus.TX_START && ns < 400) begin
      ns++;
      @(negedge CLK);
    end
    chk({nm, "_start_cycles"}, 64'(ns), 64'(exp_start));
    nw = 0;
    while (bus.ACK == 4'b0000 && nw < 400) begin
      nw++;
      @(negedge CLK);
    end
    chk({nm, "_ack_wait"}, 64'(nw), 64'(exp_wait));
    chk({nm, "_ack"}, 64'(bus.ACK), 64'(exp_g));
    chk({nm, "_err"}, 64'(bus.ERR), 64'(exp_err));
    chk({nm, "_gnt_hold"}, {52'd0, bus.GNT, bus.TX_DIN}, {52'd0, exp_g, exp_din});
    $display("txn %s: gnt=%b din=%h start=%0d wait=%0d err=%b", nm, bus.GNT, bus.TX_DIN, ns, nw, bus.ERR);
    bus.REQ[exp_w] = 1'b0;
    @(negedge CLK);
    chk({nm, "_idle"}, {54'd0, bus.ACK, bus.ERR, bus.ACTIVE, bus.GNT}, 64'd0);
  endtask

  typedef struct {
    string      nm;
    logic [3:0] req;
    logic [31:0] data;
    int         d;
    int         h;
    int         exp_w;
    logic [7:0] exp_din;
    logic       exp_err;
    int         exp_start;
    int         exp_wait;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"single",   4'b0100, 32'h11A5_2233,  5, 20, 2, 8'hA5, 1'b0,  5, 20};
    tbl[1] = '{"rr_a",     4'b0101, 32'h11A5_2233,  3,  4, 0, 8'h33, 1'b0,  3,  4};
    tbl[2] = '{"rr_b",     4'b0101, 32'h11A5_2233,  2,  1, 2, 8'hA5, 1'b0,  2,  1};
    tbl[3] = '{"timeout",  4'b1001, 32'h11A5_2233,  0,  1, 3, 8'h11, 1'b1, 16,  0};
    tbl[4] = '{"after_to", 4'b1001, 32'h11A5_2233,  4,  2, 0, 8'h33, 1'b0,  4,  2};
    tbl[5] = '{"simul",    4'b1000, 32'h5A00_0000, 16,  3, 3, 8'h5A, 1'b0, 16,  3};
    tbl[6] = '{"late",     4'b0010, 32'h0000_C300, 15,  2, 1, 8'hC3, 1'b0, 15,  2};

    RESETN   = 1'b1;
    bus.REQ  = 4'b0000;
    bus.DATA = 32'h0;
    @(negedge CLK);
    chk("reset_outputs", {42'd0, bus.GNT, bus.ACK, bus.ERR, bus.TX_START, bus.TX_DIN, bus.ACTIVE}, 64'd0);
    @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    chk("post_reset_idle", {54'd0, bus.GNT, bus.ACTIVE, bus.TX_START}, 64'd0);

    foreach (tbl[i])
      run_txn(tbl[i].nm, tbl[i].req, tbl[i].data, tbl[i].d, tbl[i].h, tbl[i].exp_w,
              tbl[i].exp_din, tbl[i].exp_err, tbl[i].exp_start, tbl[i].exp_wait, 1'b1, 1'b0);

    // Fairness: all four keep requesting; order must be 0,1,2,3,0 from reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [31:0] rr_data;
      logic [7:0]  rr_din;
      rr_data = 32'h4433_2211;
      rr_din  = rr_data[8*(k%4) +: 8];
      run_txn($sformatf("fair%0d", k), 4'b1111, rr_data, 2, 1, k % 4, rr_din, 1'b0, 2, 1, 1'b1, 1'b0);
    end
    bus.REQ = 4'b0000;

    // REQ drop and DATA change after grant must not disturb the frame.
    run_txn("drop", 4'b0010, 32'h0000_5C00, 4, 3, 1, 8'h5C, 1'b0, 4, 3, 1'b1, 1'b1);

    // Engine busy from reset blocks arbitration.
    begin
      int hits;
      force_busy = 1'b1;
      do_reset();
      bus.REQ  = 4'b0001;
      bus.DATA = 32'h0000_0096;
      hits = 0;
      repeat (8) begin
        @(negedge CLK);
        if (bus.GNT != 4'b0000 || bus.ACTIVE) hits++;
      end
      chk("blocked_nogrant", 64'(hits), 64'd0);
      force_busy = 1'b0;
      run_txn("blocked", 4'b0001, 32'h0000_0096, 2, 1, 0, 8'h96, 1'b0, 2, 1, 1'b1, 1'b0);
    end

    // Reset while in WAIT discards the frame; requester 3 wins after release.
    begin
      int t;
      bus.DATA  = 32'h0000_7E00;
      bus.REQ   = 4'b0010;
      eng_delay = 3;
      eng_hold  = 30;
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (!(bus.GNT != 4'b0000 && !bus.TX_START) && t < 100);
      @(negedge CLK);
      chk("rst_pre_wait", {58'd0, bus.ACTIVE, bus.TX_START, bus.GNT}, {58'd0, 1'b1, 1'b0, 4'b0010});
      #2;
      RESETN = 1'b1;
      #1;
      chk("rst_async", {42'd0, bus.GNT, bus.ACK, bus.ERR, bus.TX_START, bus.TX_DIN, bus.ACTIVE}, 64'd0);
      $display("txn rst_mid: gnt=%b tx_din=%h active=%b", bus.GNT, bus.TX_DIN, bus.ACTIVE);
      @(negedge CLK);
      @(negedge CLK);
      RESETN = 1'b0;
      run_txn("rst_after", 4'b1000, 32'hE700_0000, 3, 30, 3, 8'hE7, 1'b0, 3, 30, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
